// File: rtl/jelly_rtos_wb_pkg.sv
// jelly_rtos_wb_pkg: opcodes, configuration ids and the event-flag waiter record
package jelly_rtos_wb_pkg;
  localparam int DECODE_ID_POS     = 0;
  localparam int DECODE_OPCODE_POS = 8;
  localparam logic [7:0] OPCODE_REF_CFG     = 8'h00;
  localparam logic [7:0] OPCODE_SIG_SEM     = 8'h21;
  localparam logic [7:0] OPCODE_WAI_SEM     = 8'h22;
  localparam logic [7:0] OPCODE_SET_FLG     = 8'h31;
  localparam logic [7:0] OPCODE_CLR_FLG     = 8'h32;
  localparam logic [7:0] OPCODE_WAI_FLG_AND = 8'h33;
  localparam logic [7:0] OPCODE_WAI_FLG_OR  = 8'h34;
  localparam logic [7:0] REF_CFG_CORE_ID = 8'h00;
  localparam logic [7:0] REF_CFG_VERSION = 8'h01;
  localparam logic [7:0] REF_CFG_DATE    = 8'h04;
  localparam logic [7:0] REF_CFG_ERR     = 8'h08;
  localparam int FLG_TSKID_WIDTH = 4;
  localparam int FLG_PTN_WIDTH   = 32;
  typedef struct packed {
    logic                       valid;
    logic [FLG_TSKID_WIDTH-1:0] tskid;
    logic [FLG_PTN_WIDTH-1:0]   ptn;
    logic                       mode;
  } flg_waiter_t;
endpackage

// File: rtl/jelly_rtos_prio_enc.sv
// jelly_rtos_prio_enc: lowest-set-bit encoder with any-bit-set valid
module jelly_rtos_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] in_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (in_i[i]) idx_o = W'(i);
    valid_o = |in_i;
  end
endmodule

// File: rtl/jelly_rtos_wb_sync_slave.sv
// jelly_rtos_wb_sync_slave: Wishbone slave with RTOS event flags, counting semaphores
// and a valid/ready wake-up port for released tasks
module jelly_rtos_wb_sync_slave
  import jelly_rtos_wb_pkg::*;
#(
  parameter int          WB_ADR_WIDTH = 16,
  parameter int          WB_DAT_WIDTH = 32,
  parameter int          WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int          TSKID_WIDTH  = 4,
  parameter int          TASKS        = 16,
  parameter int          FLGS         = 2,
  parameter int          FLGPTN_WIDTH = 32,
  parameter int          SEMS         = 2,
  parameter int          SEMCNT_WIDTH = 4,
  parameter logic [31:0] CORE_ID      = 32'h527a_3101,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] DATE         = 32'h2020_0101
) (
  input  logic                    wb_rst_i,
  input  logic                    wb_clk_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [TSKID_WIDTH-1:0]  run_tskid_i,
  output logic                    wup_valid_o,
  output logic [TSKID_WIDTH-1:0]  wup_tskid_o,
  input  logic                    wup_ready_i
);
  localparam int FI_W = FLGS > 1 ? $clog2(FLGS) : 1;
  localparam int SI_W = SEMS > 1 ? $clog2(SEMS) : 1;

  logic                    ack_q, ack_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic [FLGPTN_WIDTH-1:0] flg_q [FLGS];
  logic [FLGPTN_WIDTH-1:0] flg_d [FLGS];
  flg_waiter_t             wtr_q [FLGS];
  flg_waiter_t             wtr_d [FLGS];
  logic [SEMCNT_WIDTH-1:0] cnt_q [SEMS];
  logic [SEMCNT_WIDTH-1:0] cnt_d [SEMS];
  logic [TASKS-1:0]        wait_q [SEMS];
  logic [TASKS-1:0]        wait_d [SEMS];
  logic [TASKS-1:0]        pend_q, pend_d, pend_set, pend_clr;
  logic                    err_q, err_d;
  logic                    wup_valid_q, wup_valid_d;
  logic [TSKID_WIDTH-1:0]  wup_tskid_q, wup_tskid_d;
  logic [7:0]              opc, id;
  logic [FI_W-1:0]         fi;
  logic [SI_W-1:0]         si;
  logic                    acc, flg_ok, sem_ok, hs;
  logic [FLGPTN_WIDTH-1:0] ptn, msk;
  logic                    sem_wv, pend_v;
  logic [TSKID_WIDTH-1:0]  sem_wi, pend_i;

  function automatic logic flg_met(input logic [FLGPTN_WIDTH-1:0] f, p, input logic or_mode);
    return or_mode ? |(f & p) : (f & p) == p;
  endfunction

  assign opc    = s_wb_adr_i[DECODE_OPCODE_POS +: 8];
  assign id     = s_wb_adr_i[DECODE_ID_POS +: 8];
  assign fi     = id[FI_W-1:0];
  assign si     = id[SI_W-1:0];
  assign flg_ok = id < 8'(FLGS);
  assign sem_ok = id < 8'(SEMS);
  assign acc    = s_wb_stb_i & ~ack_q;
  assign ptn    = s_wb_dat_i[FLGPTN_WIDTH-1:0];
  assign hs     = wup_valid_q & wup_ready_i;

  genvar b;
  for (b = 0; b < FLGPTN_WIDTH; b++) begin : g_msk
    assign msk[b] = s_wb_sel_i[b/8];
  end

  jelly_rtos_prio_enc #(.N(TASKS), .W(TSKID_WIDTH)) u_sem_enc (
    .in_i(wait_q[si]), .valid_o(sem_wv), .idx_o(sem_wi)
  );

  always_comb begin
    flg_d    = flg_q;
    wtr_d    = wtr_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    err_d    = err_q;
    pend_set = '0;
    dat_d    = '0;
    ack_d    = acc;
    // flag release looks only at registered state, so it always precedes the next access
    for (int k = 0; k < FLGS; k++)
      if (wtr_q[k].valid && flg_met(flg_q[k], FLGPTN_WIDTH'(wtr_q[k].ptn), wtr_q[k].mode)) begin
        wtr_d[k].valid = 1'b0;
        pend_set[wtr_q[k].tskid] = 1'b1;
      end
    if (acc && s_wb_we_i) begin
      case (opc)
        OPCODE_REF_CFG: if (id == REF_CFG_ERR && s_wb_dat_i[0]) err_d = 1'b0;
        OPCODE_SET_FLG: if (flg_ok) flg_d[fi] = flg_q[fi] | (ptn & msk);
        OPCODE_CLR_FLG: if (flg_ok) flg_d[fi] = flg_q[fi] & (ptn | ~msk);
        OPCODE_WAI_FLG_AND, OPCODE_WAI_FLG_OR:
          if (flg_ok) begin
            if (wtr_q[fi].valid) err_d = 1'b1;
            else if (!flg_met(flg_q[fi], ptn, opc == OPCODE_WAI_FLG_OR))
              wtr_d[fi] = '{valid: 1'b1, tskid: FLG_TSKID_WIDTH'(run_tskid_i),
                            ptn: FLG_PTN_WIDTH'(ptn), mode: opc == OPCODE_WAI_FLG_OR};
          end
        OPCODE_SIG_SEM:
          if (sem_ok) begin
            if (sem_wv) begin
              wait_d[si][sem_wi] = 1'b0;
              pend_set[sem_wi]   = 1'b1;
            end else if (&cnt_q[si]) err_d = 1'b1;
            else cnt_d[si] = cnt_q[si] + SEMCNT_WIDTH'(1);
          end
        OPCODE_WAI_SEM:
          if (sem_ok) begin
            if (cnt_q[si] != '0) cnt_d[si] = cnt_q[si] - SEMCNT_WIDTH'(1);
            else wait_d[si][run_tskid_i] = 1'b1;
          end
        default: ;
      endcase
    end
    if (acc && !s_wb_we_i) begin
      case (opc)
        OPCODE_REF_CFG:
          dat_d = id == REF_CFG_CORE_ID ? WB_DAT_WIDTH'(CORE_ID) :
                  id == REF_CFG_VERSION ? WB_DAT_WIDTH'(VERSION) :
                  id == REF_CFG_DATE    ? WB_DAT_WIDTH'(DATE)    :
                  id == REF_CFG_ERR     ? WB_DAT_WIDTH'(err_q)   : '0;
        OPCODE_SET_FLG: dat_d = flg_ok ? WB_DAT_WIDTH'(flg_q[fi]) : '0;
        OPCODE_WAI_SEM: dat_d = sem_ok ? WB_DAT_WIDTH'(cnt_q[si]) : '0;
        default: ;
      endcase
    end
  end

  // a release landing on the bit being accepted keeps it pending
  assign pend_clr = hs ? {{(TASKS-1){1'b0}}, 1'b1} << wup_tskid_q : '0;
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  jelly_rtos_prio_enc #(.N(TASKS), .W(TSKID_WIDTH)) u_wup_enc (
    .in_i(pend_d), .valid_o(pend_v), .idx_o(pend_i)
  );

  // the presented task id only moves once the scheduler has taken it
  always_comb begin
    wup_valid_d = (!wup_valid_q || hs) ? pend_v : wup_valid_q;
    wup_tskid_d = (!wup_valid_q || hs) ? pend_i : wup_tskid_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
      wup_valid_q <= 1'b0;
      wup_tskid_q <= '0;
      for (int k = 0; k < FLGS; k++) begin
        flg_q[k] <= '0;
        wtr_q[k] <= '0;
      end
      for (int k = 0; k < SEMS; k++) begin
        cnt_q[k]  <= '0;
        wait_q[k] <= '0;
      end
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      wup_valid_q <= wup_valid_d;
      wup_tskid_q <= wup_tskid_d;
      flg_q       <= flg_d;
      wtr_q       <= wtr_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
    end
  end

  assign s_wb_ack_o  = ack_q;
  assign s_wb_dat_o  = dat_q;
  assign wup_valid_o = wup_valid_q;
  assign wup_tskid_o = wup_tskid_q;
endmodule

// File: tb/tb_jelly_rtos_wb_sync_slave.sv
// tb_jelly_rtos_wb_sync_slave: scoreboard bench; read data and wake-ups are queued
// when stimulus is driven and compared when the slave produces them
module tb_jelly_rtos_wb_sync_slave;
  logic        wb_rst_i = 1'b0;
  logic        wb_clk_i = 1'b0;
  logic [15:0] s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i = 1'b0;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic [3:0]  run_tskid_i = '0;
  logic        wup_valid_o;
  logic [3:0]  wup_tskid_o;
  logic        wup_ready_i = 1'b1;

  int          n_chk = 0;
  int          n_err = 0;
  logic        rd_act = 1'b0;
  logic [31:0] rd_q [$];
  logic [3:0]  wup_q [$];

  jelly_rtos_wb_sync_slave dut (
    .wb_rst_i(wb_rst_i), .wb_clk_i(wb_clk_i),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o), .run_tskid_i(run_tskid_i),
    .wup_valid_o(wup_valid_o), .wup_tskid_o(wup_tskid_o), .wup_ready_i(wup_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (s_wb_ack_o && rd_act) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data", s_wb_dat_o, rd_q.pop_front());
    end
    if (wup_valid_o && wup_ready_i) begin
      if (wup_q.size() == 0) check("wup_unexpected", {28'd0, wup_tskid_o}, 32'hffff_ffff);
      else check("wup_tskid", {28'd0, wup_tskid_o}, {28'd0, wup_q.pop_front()});
    end
  end

  task automatic wb(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic [31:0] exp);
    int n = 0;
    if (!we) rd_q.push_back(exp);
    rd_act = !we;
    s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_stb_i = 1'b1;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!s_wb_ack_o && n < 8);
    check("ack_rise", s_wb_ack_o, 1);
    s_wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("ack_one_cycle", s_wb_ack_o, 0);
    check("dat_idle_zero", s_wb_dat_o, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (wup_q.size() != 0 && n < 20) begin
      @(posedge wb_clk_i); n++;
    end
    #1;
    check("wup_drain", wup_q.size(), 0);
  endtask

  task automatic pulse_ready();
    wup_ready_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wup_ready_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", s_wb_ack_o, 0);
    check("rst_dat", s_wb_dat_o, 0);
    check("rst_wup_valid", wup_valid_o, 0);
    check("rst_wup_tskid", wup_tskid_o, 0);
    wb_rst_i = 1'b1;
    idle(1);
    wb(0, 16'h0000, 0, 4'hf, 32'h527a_3101);
    wb(0, 16'h0001, 0, 4'hf, 32'h0001_0000);
    wb(0, 16'h0004, 0, 4'hf, 32'h2020_0101);
    // AND wait on flag 0 released only once all pattern bits are present
    run_tskid_i = 4'd3;
    wb(1, 16'h3300, 32'h5, 4'hf, 0);
    wb(1, 16'h3100, 32'h1, 4'hf, 0);
    idle(4);
    wup_q.push_back(4'd3);
    wb(1, 16'h3100, 32'h4, 4'hf, 0);
    drain();
    wb(0, 16'h3100, 0, 4'hf, 32'h5);
    // semaphore 1: wait, signal hands over, second signal counts
    run_tskid_i = 4'd2;
    wb(1, 16'h2201, 0, 4'hf, 0);
    wup_q.push_back(4'd2);
    wb(1, 16'h2101, 0, 4'hf, 0);
    drain();
    wb(0, 16'h2201, 0, 4'hf, 32'h0);
    wb(1, 16'h2101, 0, 4'hf, 0);
    wb(0, 16'h2201, 0, 4'hf, 32'h1);
    // wake-up port hold with pend {2,5}
    wup_ready_i = 1'b0;
    run_tskid_i = 4'd5;
    wb(1, 16'h2200, 0, 4'hf, 0);
    run_tskid_i = 4'd2;
    wb(1, 16'h2200, 0, 4'hf, 0);
    wb(1, 16'h2100, 0, 4'hf, 0);
    check("hold_valid_a", wup_valid_o, 1);
    check("hold_tskid_a", wup_tskid_o, 2);
    wb(1, 16'h2100, 0, 4'hf, 0);
    idle(3);
    check("hold_valid_b", wup_valid_o, 1);
    check("hold_tskid_b", wup_tskid_o, 2);
    wup_q.push_back(4'd2);
    pulse_ready();
    check("next_valid", wup_valid_o, 1);
    check("next_tskid", wup_tskid_o, 5);
    wup_q.push_back(4'd5);
    pulse_ready();
    check("empty_valid", wup_valid_o, 0);
    check("hold_drained", wup_q.size(), 0);
    wup_ready_i = 1'b1;
    wb(0, 16'h2200, 0, 4'hf, 32'h0);
    // second waiter on flag 0 rejected, error sticky until cleared
    run_tskid_i = 4'd3;
    wb(1, 16'h3300, 32'h8, 4'hf, 0);
    run_tskid_i = 4'd7;
    wb(1, 16'h3400, 32'h10, 4'hf, 0);
    wb(0, 16'h0008, 0, 4'hf, 32'h1);
    wb(1, 16'h0008, 32'h1, 4'hf, 0);
    wb(0, 16'h0008, 0, 4'hf, 32'h0);
    wup_q.push_back(4'd3);
    wb(1, 16'h3100, 32'h8, 4'hf, 0);
    drain();
    run_tskid_i = 4'd9;
    wb(1, 16'h3400, 32'h1, 4'hf, 0);
    idle(3);
    wb(0, 16'h0008, 0, 4'hf, 32'h0);
    // byte-masked set and clear
    wb(1, 16'h3100, 32'hffff_ffff, 4'b0010, 0);
    wb(1, 16'h3200, 32'h0, 4'b0001, 0);
    wb(0, 16'h3100, 0, 4'hf, 32'h0000_ff00);
    // set then clear on consecutive accesses still releases
    run_tskid_i = 4'd6;
    wb(1, 16'h3301, 32'h1, 4'hf, 0);
    wup_q.push_back(4'd6);
    wb(1, 16'h3101, 32'h1, 4'hf, 0);
    wb(1, 16'h3201, 32'h0, 4'hf, 0);
    drain();
    wb(0, 16'h3101, 0, 4'hf, 32'h0);
    // counter saturation
    run_tskid_i = 4'd1;
    wb(1, 16'h2201, 0, 4'hf, 0);
    wb(0, 16'h2201, 0, 4'hf, 32'h0);
    for (int i = 0; i < 16; i++) wb(1, 16'h2101, 0, 4'hf, 0);
    wb(0, 16'h2201, 0, 4'hf, 32'hf);
    wb(0, 16'h0008, 0, 4'hf, 32'h1);
    // unknown opcode and out-of-range ids
    wb(0, 16'h7700, 0, 4'hf, 32'h0);
    wb(1, 16'h3105, 32'hff, 4'hf, 0);
    wb(0, 16'h3105, 0, 4'hf, 32'h0);
    wb(0, 16'h2202, 0, 4'hf, 32'h0);
    wb(0, 16'h0002, 0, 4'hf, 32'h0);
    // reset in the middle of an acknowledged access
    wup_ready_i = 1'b0;
    run_tskid_i = 4'd4;
    wb(1, 16'h2200, 0, 4'hf, 0);
    wb(1, 16'h2100, 0, 4'hf, 0);
    check("pre_rst_valid", wup_valid_o, 1);
    check("pre_rst_tskid", wup_tskid_o, 4);
    rd_act = 1'b0;
    s_wb_we_i = 1'b0; s_wb_adr_i = 16'h0000; s_wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("pre_rst_ack", s_wb_ack_o, 1);
    wb_rst_i = 1'b0;
    #1;
    check("mid_rst_ack", s_wb_ack_o, 0);
    check("mid_rst_dat", s_wb_dat_o, 0);
    check("mid_rst_wup_valid", wup_valid_o, 0);
    check("mid_rst_wup_tskid", wup_tskid_o, 0);
    s_wb_stb_i = 1'b0;
    idle(2);
    wb_rst_i = 1'b1;
    wup_ready_i = 1'b1;
    idle(1);
    wb(0, 16'h3100, 0, 4'hf, 32'h0);
    wb(0, 16'h2201, 0, 4'hf, 32'h0);
    wb(0, 16'h0008, 0, 4'hf, 32'h0);
    wb(1, 16'h2100, 0, 4'hf, 0);
    idle(3);
    wb(0, 16'h2200, 0, 4'hf, 32'h1);
    check("rd_queue_empty", rd_q.size(), 0);
    check("wup_queue_empty", wup_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
